// File: rtl/game_pkg.sv
// Shared encodings for the memory-game turn controller and the HUD that
// decodes its winner and cur_player outputs.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_SWITCH = 2'd2,
      ST_OVER   = 2'd3
   } game_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   localparam logic PLAYER_1 = 1'b0;
   localparam logic PLAYER_2 = 1'b1;

   localparam logic [3:0] SCORE_MAX = 4'd9;

   function automatic logic [3:0] score_inc(input logic [3:0] score);
      return (score >= SCORE_MAX) ? SCORE_MAX : score + 4'd1;
   endfunction

   function automatic logic [1:0] decide_winner(input logic [3:0] p1, input logic [3:0] p2);
      if (p1 > p2)      return WIN_P1;
      else if (p2 > p1) return WIN_P2;
      else              return WIN_TIE;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts while run is high, wraps at the terminal
// count and pulses tick for that cycle; clear forces the count back to zero.
module sec_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 50000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         count <= (count == TERM) ? '0 : count + CW'(1);
      end
   end

   assign tick = run && !clear && (count == TERM);

endmodule

// File: rtl/game_turn_ctrl.sv
// Two-player memory-game turn controller: per-turn countdown, scoring,
// turn hand-over and end-of-game winner decision.
module game_turn_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50000000,
   parameter int unsigned TURN_SECONDS  = 15,
   parameter int unsigned NUM_PAIRS     = 8
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       start,
   input  logic       pair_valid,
   input  logic       pair_match,
   output logic       cur_player,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [3:0] time_left,
   output logic [1:0] winner,
   output logic       in_play,
   output logic       turn_change
);

   localparam logic [3:0] TURN_LD  = 4'(TURN_SECONDS);
   localparam logic [3:0] PAIRS_LD = 4'(NUM_PAIRS);

   game_state_t state, state_nxt;
   logic [3:0]  matched, matched_nxt, matched_inc;
   logic [3:0]  p1_nxt, p2_nxt, time_nxt;
   logic [1:0]  winner_nxt;
   logic        cur_nxt, in_play_nxt, turn_change_nxt;
   logic        tick, presc_clear, presc_run, last_pair;

   assign matched_inc = matched + 4'd1;
   assign last_pair   = (matched_inc == PAIRS_LD);

   // Any pair result in PLAY restarts the second count (match reload or exit).
   assign presc_run   = (state == ST_PLAY);
   assign presc_clear = (state != ST_PLAY) || pair_valid;

   sec_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clock  (CLOCK_50),
      .reset_n(reset_n),
      .clear  (presc_clear),
      .run    (presc_run),
      .tick   (tick)
   );

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_OVER: if (start) state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (pair_valid) begin
               if (!pair_match)    state_nxt = ST_SWITCH;
               else if (last_pair) state_nxt = ST_OVER;
            end else if (tick && time_left == 4'd1) begin
               state_nxt = ST_SWITCH;
            end
         end
         ST_SWITCH: state_nxt = ST_PLAY;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      p1_nxt          = p1_score;
      p2_nxt          = p2_score;
      time_nxt        = time_left;
      winner_nxt      = winner;
      cur_nxt         = cur_player;
      matched_nxt     = matched;
      turn_change_nxt = 1'b0;
      in_play_nxt     = (state_nxt == ST_PLAY) || (state_nxt == ST_SWITCH);
      unique case (state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               p1_nxt      = '0;
               p2_nxt      = '0;
               matched_nxt = '0;
               cur_nxt     = PLAYER_1;
               time_nxt    = TURN_LD;
               winner_nxt  = WIN_NONE;
            end
         end
         ST_PLAY: begin
            if (pair_valid && pair_match) begin
               if (cur_player == PLAYER_1) p1_nxt = score_inc(p1_score);
               else                        p2_nxt = score_inc(p2_score);
               matched_nxt = matched_inc;
               time_nxt    = TURN_LD;
               if (last_pair) winner_nxt = decide_winner(p1_nxt, p2_nxt);
            end else if (!pair_valid && tick) begin
               time_nxt = time_left - 4'd1;
            end
         end
         ST_SWITCH: begin
            cur_nxt         = ~cur_player;
            time_nxt        = TURN_LD;
            turn_change_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         cur_player  <= PLAYER_1;
         p1_score    <= '0;
         p2_score    <= '0;
         time_left   <= TURN_LD;
         winner      <= WIN_NONE;
         in_play     <= 1'b0;
         turn_change <= 1'b0;
         matched     <= '0;
      end else begin
         cur_player  <= cur_nxt;
         p1_score    <= p1_nxt;
         p2_score    <= p2_nxt;
         time_left   <= time_nxt;
         winner      <= winner_nxt;
         in_play     <= in_play_nxt;
         turn_change <= turn_change_nxt;
         matched     <= matched_nxt;
      end
   end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50000000, CLOCK_50 cycles per one-second tick.
REQ-002 Parameter TURN_SECONDS, default 15, per-turn countdown start value (1..15).
REQ-003 Parameter NUM_PAIRS, default 8, total card pairs on the board (1..9).
REQ-004 CLOCK_50  in  1  sole clock; all flops on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a game from IDLE or OVER.
REQ-007 pair_valid  in  1  one-cycle pulse from the card matcher: the current player has revealed a second card.
REQ-008 pair_match  in  1  qualifies pair_valid: 1 = cards match, 0 = mismatch.
REQ-009 cur_player  out  1  0 = P1 to move, 1 = P2 to move.
REQ-010 p1_score, p2_score  out  4 each  binary pair count, 0..9, fed to the HUD score digits.
REQ-011 time_left  out  4  seconds remaining in the current turn, fed to the HUD timer digits.
REQ-012 winner  out  2  00 none, 01 P1, 10 P2, 11 tie.
REQ-013 in_play  out  1  high while in PLAY or SWITCH.
REQ-014 turn_change  out  1  one-cycle pulse when cur_player toggles.

Function
REQ-015 FSM states: IDLE, PLAY, SWITCH, OVER; state register and all outputs are registered.
REQ-016 IDLE/OVER + start -> PLAY next cycle: scores 0, matched-pair count 0, cur_player 0, time_left TURN_SECONDS, winner 00, prescaler cleared.
REQ-017 Prescaler counts 0..TICKS_PER_SEC-1 only in PLAY, issuing a one-cycle tick at terminal count; cleared on every turn start, match, and exit from PLAY.
REQ-018 PLAY + tick with time_left > 1: time_left decrements by 1.
REQ-019 PLAY + tick with time_left == 1: time_left becomes 0, FSM -> SWITCH (timeout).
REQ-020 PLAY + pair_valid & pair_match: current player's score +1 (saturating at 9), matched count +1, time_left reloads TURN_SECONDS, player keeps the turn; visible the cycle after pair_valid.
REQ-021 If the increment in REQ-020 makes matched count equal NUM_PAIRS: FSM -> OVER in the same update; winner set from final scores (higher wins, equal = 11).
REQ-022 PLAY + pair_valid & !pair_match: FSM -> SWITCH; scores unchanged.
REQ-023 SWITCH lasts exactly one cycle: cur_player toggles, time_left reloads TURN_SECONDS, turn_change pulses, FSM -> PLAY.
REQ-024 pair_valid and a tick in the same cycle: the pair result wins, the tick is discarded.
REQ-025 pair_valid is ignored in IDLE, SWITCH, and OVER; start is ignored in PLAY and SWITCH.
REQ-026 OVER holds scores, time_left, and winner stable until start or reset.

Reset
REQ-027 reset_n low asynchronously forces IDLE, cur_player 0, both scores 0, time_left TURN_SECONDS, winner 00, in_play 0, turn_change 0, prescaler 0, matched count 0.
REQ-028 Reset asserted mid-game abandons the game; no partial score survives.

Structure
REQ-029 Shared package game_pkg holds the state enum, the winner encodings, and the player encodings, so the HUD decodes winner and cur_player from one definition.
REQ-030 Prescaler is a separate sub-module, sec_prescaler (inputs: clock, reset_n, clear, run; output: tick).

Verification (TICKS_PER_SEC=4, TURN_SECONDS=3, NUM_PAIRS=2)
REQ-031 Reset, then start -> next cycle in_play=1, cur_player=0, time_left=3, scores 0/0.
REQ-032 No pair_valid for 12 cycles after start -> time_left steps 3,2,1,0; one-cycle turn_change; cur_player=1; time_left=3.
REQ-033 pair_valid with pair_match=0 -> one-cycle SWITCH, cur_player toggles, p1_score unchanged.
REQ-034 Two matches by P1 -> p1_score=1 then 2, game over, winner=01, in_play=0; later pair_valid is ignored.
REQ-035 One match each -> winner=11; pair_valid coinciding with the final tick -> match scored, no timeout switch.
REQ-036 reset_n pulsed low mid-turn (asynchronous, between clock edges) -> outputs immediately at reset values; start restarts cleanly.
